// File: rtl/mips_cpu_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// mips_cpu_pkg
// Shared definitions for the HI/LO multiply/divide unit: operation and FSM
// encodings, the iteration count and a magnitude helper used when preparing
// signed operands.
// -----------------------------------------------------------------------------
package mips_cpu_pkg;

  localparam int unsigned MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_ITER = 2'b10,
    ST_FIX  = 2'b11
  } muldiv_state_t;

  // Two's-complement magnitude of v when neg is set, v unchanged otherwise.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_divstep.sv
// -----------------------------------------------------------------------------
// mips_cpu_divstep
// One combinational restoring-division step.
//   pair_i    : {remainder[31:0], dividend/quotient[31:0]}
//   divisor_i : divisor magnitude
//   pair_o    : pair after shift-left, trial subtract and quotient-bit insert
// -----------------------------------------------------------------------------
module mips_cpu_divstep (
  input  logic [63:0] pair_i,
  input  logic [31:0] divisor_i,
  output logic [63:0] pair_o
);

  logic [32:0] rem_sh_s;  // remainder after the left shift, 33 bits wide
  logic        ge_s;
  logic [31:0] diff_s;

  // The shifted remainder can exceed 32 bits, so the compare uses all 33;
  // the difference always fits 32 bits whenever it is kept.
  always_comb begin
    rem_sh_s = pair_i[63:31];
    ge_s     = (rem_sh_s >= {1'b0, divisor_i});
    diff_s   = rem_sh_s[31:0] - divisor_i;
    if (ge_s) begin
      pair_o = {diff_s, pair_i[30:0], 1'b1};
    end else begin
      pair_o = {pair_i[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// -----------------------------------------------------------------------------
// mips_cpu_muldiv
// Iterative multiply/divide unit owning the HI/LO registers.
//   clk_i, reset_i (sync, active-high)
//   start_i, op_i[1:0], a_i[31:0], b_i[31:0] : operation request (IDLE only)
//   mthi_en_i, mtlo_en_i, wdata_i[31:0]      : MTHI/MTLO writes
//   busy_o : operation in flight, done_o : one-cycle result pulse
//   hi_o, lo_o : HI/LO registers
// Optional build macro MULDIV_FAST_MULT_EN: multiplies are computed in one
// combinational step in PREP and skip ITER (3-cycle latency). Divide is
// always iterative.
// -----------------------------------------------------------------------------
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        mthi_en_i,
  input  logic        mtlo_en_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [4:0] LAST_STEP = 5'(MULDIV_ITERS - 1);

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [63:0]   acc_q, acc_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          sa_q, sa_d, sb_q, sb_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          done_q, done_d;

  logic          is_mul_s, is_signed_s;
  logic [32:0]   mul_sum_s;
  logic [63:0]   mul_next_s, div_next_s, prod_s;
  logic [31:0]   res_hi_s, res_lo_s;

  assign is_mul_s    = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign is_signed_s = (op_q == OP_MULT) || (op_q == OP_DIV);

  mips_cpu_divstep u_divstep (
    .pair_i    (acc_q),
    .divisor_i (opnd_q),
    .pair_o    (div_next_s)
  );

  // Shift-add multiply step; the 33-bit sum keeps its carry as the new MSB.
  always_comb begin
    mul_sum_s = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    if (acc_q[0]) begin
      mul_next_s = {mul_sum_s, acc_q[31:1]};
    end else begin
      mul_next_s = {1'b0, acc_q[63:1]};
    end
  end

  // Sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    if (sa_q ^ sb_q) begin
      prod_s = 64'd0 - acc_q;
    end else begin
      prod_s = acc_q;
    end
    if (is_mul_s) begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end else if (b_q == 32'd0) begin
      res_hi_s = a_q;
      res_lo_s = 32'd0;
    end else begin
      res_lo_s = mag32(acc_q[31:0], sa_q ^ sb_q);
      res_hi_s = mag32(acc_q[63:32], sa_q);
    end
  end

  // Next-state logic for the FSM, datapath and HI/LO.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    done_d  = 1'b0;
    if (mthi_en_i) begin
      hi_d = wdata_i;
    end else begin
      hi_d = hi_q;
    end
    if (mtlo_en_i) begin
      lo_d = wdata_i;
    end else begin
      lo_d = lo_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_PREP;
          op_d    = muldiv_op_t'(op_i);
          a_d     = a_i;
          b_d     = b_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        sa_d  = is_signed_s & a_q[31];
        sb_d  = is_signed_s & b_q[31];
        cnt_d = 5'd0;
        // Multiplier / dividend sits in the low half and shifts out as the
        // product / quotient shifts in.
        if (is_mul_s) begin
          opnd_d = mag32(a_q, is_signed_s & a_q[31]);
          acc_d  = {32'd0, mag32(b_q, is_signed_s & b_q[31])};
        end else begin
          opnd_d = mag32(b_q, is_signed_s & b_q[31]);
          acc_d  = {32'd0, mag32(a_q, is_signed_s & a_q[31])};
        end
`ifdef MULDIV_FAST_MULT_EN
        if (is_mul_s) begin
          acc_d   = {32'd0, mag32(a_q, is_signed_s & a_q[31])} *
                    {32'd0, mag32(b_q, is_signed_s & b_q[31])};
          state_d = ST_FIX;
        end else begin
          state_d = ST_ITER;
        end
`else
        state_d = ST_ITER;
`endif
      end
      ST_ITER: begin
        if (is_mul_s) begin
          acc_d = mul_next_s;
        end else begin
          acc_d = div_next_s;
        end
        if (cnt_q == LAST_STEP) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_FIX: begin
        // Result takes priority over a same-cycle MTHI/MTLO.
        hi_d    = res_hi_s;
        lo_d    = res_lo_s;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      opnd_q  <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_muldiv
// Self-checking bench: directed cases plus randomized operations compared
// against an arithmetic reference model. Inputs change #1 after the rising
// edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi_en, mtlo_en;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_cpu_muldiv dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (start),
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .mthi_en_i (mthi_en),
    .mtlo_en_i (mtlo_en),
    .wdata_i   (wdata),
    .busy_o    (busy),
    .done_o    (done),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, m;
    logic [63:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    r  = 64'd0;
    case (o)
      2'd0: r = sx * sy;
      2'd1: r = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) begin
          r = {x, 32'd0};
        end else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) r = {x, 32'd0};
        else            r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MULT_EN
    if (o[1] == 1'b0) return 3;
`endif
    return 35;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, follow it to done, check latency, busy and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] exp;
    int n, done_at, gaps;
    exp   = ref_result(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom;
    n = 1; done_at = 0; gaps = 0;
    while (n <= 45 && done_at == 0) begin
      if (done) begin
        done_at = n;
      end else begin
        if (!busy) gaps++;
        tick();
        n++;
      end
    end
    check({tag, "_lat"}, 64'(done_at), 64'(exp_lat(o)));
    check({tag, "_busy"}, 64'(gaps), 64'd0);
    check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    check({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n_done, cyc;
    reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    mthi_en = 1'b0; mtlo_en = 1'b0; wdata = 32'd0;
    repeat (3) tick();
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    tick();

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7);
    check("divu_const", {hi, lo}, {32'd2, 32'd14});
    run_op("divu_zero", 2'd3, 32'h0000_1234, 32'd0);
    check("divu_zero_const", {hi, lo}, {32'h0000_1234, 32'd0});
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op("div_zero_neg", 2'd2, 32'hFFFF_FF00, 32'd0);

    // Ignored start during busy, MT writes in IDLE / mid-op / FIX.
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
    mtlo_en = 1'b1; wdata = 32'h0000_1357;
    tick();
    start = 1'b0; mtlo_en = 1'b0;
    check("mt_with_start", {32'd0, lo}, {32'd0, 32'h0000_1357});
    n_done = 0;
    for (cyc = 1; cyc <= 45; cyc++) begin
      if (done) begin
        n_done++;
        check("busy_done_cycle", 64'(cyc), 64'd35);
        check("busy_result", {hi, lo}, {32'd2, 32'd14});
      end
      if (cyc == 11) check("mthi_mid", {32'd0, hi}, {32'd0, 32'h0000_AAAA});
      start = (cyc == 5) ? 1'b1 : 1'b0;
      op = 2'd1; a = 32'd3; b = 32'd5;
      mthi_en = (cyc == 10);
      mtlo_en = (cyc == 34);
      wdata = (cyc == 10) ? 32'h0000_AAAA : 32'h0000_5555;
      tick();
    end
    start = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0;
    check("busy_one_done", 64'(n_done), 64'd1);

    // Reset mid-operation abandons it.
    start = 1'b1; op = 2'd3; a = 32'hDEAD_BEEF; b = 32'd3;
    tick();
    start = 1'b0;
    for (cyc = 1; cyc < 20; cyc++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    n_done = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (done) n_done++;
      tick();
    end
    check("midrst_no_done", 64'(n_done), 64'd0);
    run_op("after_rst", 2'd3, 32'hDEAD_BEEF, 32'd3);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Iterative multiply/divide unit that owns the HI/LO architectural registers. It accepts MULT, MULTU, DIV and DIVU requests from the execute stage through a start/busy/done handshake and serves MFHI/MFLO reads. It accepts MTHI/MTLO writes. It replaces the single-cycle combinational product and quotient paths with a 32-step shift-add multiplier and a 32-step restoring divider, which takes the wide arithmetic off the execute critical path.

## Interface
- No parameters. Iteration count is fixed at 32; see `MULDIV_ITERS` under Structure.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request pulse. Sampled only in IDLE.
- `op` in 2: operation select.
  - 00 = MULT
  - 01 = MULTU
  - 10 = DIV
  - 11 = DIVU
- `a` in 32: multiplicand or dividend. Sampled with `start`.
- `b` in 32: multiplier or divisor. Sampled with `start`.
- `mthi_en` in 1: write `wdata` to HI.
- `mtlo_en` in 1: write `wdata` to LO.
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: operation in flight. The pipeline stalls MFHI/MFLO and MULT/DIV while it is high.
- `done` out 1: one-cycle pulse when HI/LO take a new result.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- FSM states: IDLE, PREP, ITER, FIX.
- **IDLE**
  - `start`=1 latches `op`, `a` and `b`, then moves to PREP.
  - `start` is ignored in every other state.
- **PREP**
  - Signed ops: take the magnitudes |a| and |b| and record the sign flags.
  - Clear the 64-bit accumulator and set the step counter to 0.
- **ITER**: 32 cycles, counter 0..31.
  - Multiply: if the LSB of the multiplier is set, add the multiplicand to the upper accumulator, then shift right 1. The 33-bit add keeps its carry.
  - Divide: shift the remainder/quotient pair left 1 and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1.
  - Leave ITER when the counter reaches 31.
- **FIX**
  - Signed multiply: negate the 64-bit product when the operand signs differ.
  - Signed divide: negate the quotient when the signs differ. Negate the remainder when `a` is negative.
  - Write HI = upper/remainder and LO = lower/quotient, assert `done`, return to IDLE.
- Divide by zero (b = 0, DIV or DIVU): HI = `a`, LO = 0. The iterations still run and latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the two's-complement wrap.
- MTHI/MTLO
  - Take effect at the next edge in any state.
  - An in-flight operation overwrites both registers at FIX.
  - If `mt*_en` is high in the FIX cycle, the result wins.
- `start` together with `mt*_en` in IDLE: both are honoured. The MT write lands now; the result later overwrites it.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, FSM in IDLE.
- `start` sampled at edge T.
  - `busy` is high from T+1 through T+34.
  - `done` is high only in cycle T+35.
  - `hi`/`lo` hold the new result from T+35.
  - Total latency: 35 cycles.
- `busy` is low in the `done` cycle, so a back-to-back `start` is accepted at T+35.
- `reset` asserted mid-operation: the operation is abandoned at the next edge. All outputs return to their reset values and no `done` is produced.
- `hi` and `lo` are registered outputs with no combinational path from the inputs.

## Configuration
- Macro: `MULDIV_FAST_MULT_EN`.
- Defined:
  - MULT and MULTU compute the 64-bit product combinationally in PREP, then go straight to FIX.
  - Multiply latency is 3 cycles: `busy` high T+1..T+2, `done` at T+3.
  - Divide is unchanged.
- Undefined: iterative multiply, 35 cycles as above.

## Structure
- Shared package `mips_cpu_pkg` holds:
  - `muldiv_op_t` enum (MULT, MULTU, DIV, DIVU).
  - `muldiv_state_t` enum (IDLE, PREP, ITER, FIX).
  - `MULDIV_ITERS` = 32.
- Sub-module `mips_cpu_divstep`: combinational single restoring-division step.
  - Inputs: 64-bit remainder/quotient pair and 32-bit divisor.
  - Output: next pair.
  - Instantiated once and used by ITER.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. `done` at T+35, or T+3 with `MULDIV_FAST_MULT_EN`.
- MULT 0xFFFFFFFD (-3) × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB (-21).
- DIV -7 / 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIVU 100 / 7 -> LO = 14, HI = 2.
- DIVU 0x1234 / 0 -> HI = 0x1234, LO = 0. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- `start` pulsed at T+5 during busy -> ignored; exactly one `done`. MTHI 0xAAAA at T+10 -> `hi` = 0xAAAA from T+11, then the result at T+35.
- `reset` at T+20 -> `hi` = `lo` = 0, `busy` = 0, no `done`. A new `start` after reset completes normally.
